// File: rtl/registro_serie_paralelo.sv
`default_nettype none
// ============================================================================
// Module   : registro_serie_paralelo
// Purpose  : Framed MSB-first serial-to-parallel receiver with word FIFO,
//            valid/ack output handshake and overrun / framing error flags.
// Revision : 1.0 - initial release
// ============================================================================

module registro_serie_paralelo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             serial_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ack,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [c_CW-1:0]   cnt_q, cnt_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [c_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_AW:0]     count_q, count_d;

    logic              w_push;
    logic [WIDTH-1:0]  w_word;
    logic              w_pop;
    logic              w_full;
    logic              w_wr;
    logic              w_ovr_set;

    // Word assembly: the incoming bit always enters at the LSB side.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
        w_push      = 1'b0;
        w_word      = {shift_q[WIDTH-2:0], serial_in};

        case (state_q)
            ST_IDLE: begin
                if (bit_valid && start) begin
                    shift_d = {{(WIDTH-1){1'b0}}, serial_in};
                    cnt_d   = c_CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_valid) begin
                    if (start) begin
                        // Restart mid-word: partial word is dropped, this bit opens a new one.
                        shift_d     = {{(WIDTH-1){1'b0}}, serial_in};
                        cnt_d       = c_CW'(1);
                        frame_err_d = 1'b1;
                    end else begin
                        shift_d = w_word;
                        if (cnt_q == c_LAST) begin
                            w_push  = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + c_CW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FIFO bookkeeping; a pop in the same cycle frees the slot for a push when full.
    always_comb begin
        w_pop     = data_ack && (count_q != '0);
        w_full    = (count_q == c_FULL);
        w_wr      = w_push && (!w_full || w_pop);
        w_ovr_set = w_push && w_full && !w_pop;

        rd_ptr_d  = w_pop ? rd_ptr_q + c_AW'(1) : rd_ptr_q;
        wr_ptr_d  = w_wr  ? wr_ptr_q + c_AW'(1) : wr_ptr_q;

        count_d   = count_q;
        if (w_wr && !w_pop) begin
            count_d = count_q + (c_AW + 1)'(1);
        end else if (!w_wr && w_pop) begin
            count_d = count_q - (c_AW + 1)'(1);
        end

        overrun_d = overrun_q;
        if (w_ovr_set) begin
            overrun_d = 1'b1;
        end else if (clr_err) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr) begin
            mem_q[wr_ptr_q] <= w_word;
        end
    end

    assign data_valid = (count_q != '0);
    assign data_out   = data_valid ? mem_q[rd_ptr_q] : '0;
    assign busy       = (state_q == ST_SHIFT);
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_registro_serie_paralelo.sv
`default_nettype none
// Testbench for registro_serie_paralelo: table-driven words plus corner-case
// sequences, with a queue scoreboard holding the words the FIFO should return.

module tb_registro_serie_paralelo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             serial_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             data_ack = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;
    logic             frame_err;

    registro_serie_paralelo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .busy       (busy),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] word;
        int         gap;
        logic [3:0] exp;
    } vec_t;

    vec_t            vecs [5];
    logic [3:0]      sb [$];
    int              n_cmp = 0;
    int              n_err = 0;
    int              fe_cnt = 0;
    logic            exp_ovr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_err) fe_cnt++;
    endtask

    task automatic model_push(input logic [3:0] w);
        if (sb.size() < DEPTH) sb.push_back(w);
        else exp_ovr = 1'b1;
    endtask

    task automatic send_bit(input logic s, input logic b);
        start     = s;
        serial_in = b;
        bit_valid = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w, input int gap, input bit chk_busy);
        for (int i = 3; i >= 0; i--) begin
            send_bit(i == 3, w[i]);
            if (i != 0) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (chk_busy) chk("busy_gap", busy, 1'b1);
                end
            end
        end
        model_push(w);
    endtask

    task automatic pop_check(input string name);
        int wait_cyc = 0;
        logic [3:0] e;
        while (!data_valid && wait_cyc < 10) begin
            tick();
            wait_cyc++;
        end
        if (!data_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got data_valid=0 expected 1 within 10 cycles", name);
        end else if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got word %0h expected no word", name, data_out);
        end else begin
            e = sb.pop_front();
            chk(name, data_out, e);
            data_ack = 1'b1;
            tick();
            data_ack = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{4'b1011, 0, 4'hB};
        vecs[1] = '{4'b0110, 2, 4'h6};
        vecs[2] = '{4'b0000, 0, 4'h0};
        vecs[3] = '{4'b1111, 1, 4'hF};
        vecs[4] = '{4'b1001, 3, 4'h9};

        // Reset state
        #1;
        chk("rst_data_out", data_out, 4'h0);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        #12 rst = 1'b1;
        tick();

        // Table-driven single words with varying bit gaps
        for (int v = 0; v < 5; v++) begin
            fe_cnt = 0;
            send_word(vecs[v].word, vecs[v].gap, vecs[v].gap > 0);
            chk("word_valid_latency", data_valid, 1'b1);
            chk("word_busy_done", busy, 1'b0);
            chk("word_data", data_out, vecs[v].exp);
            pop_check("word_pop");
            chk("word_ack_empty", data_valid, 1'b0);
            chk("word_no_frame_err", fe_cnt, 0);
        end

        // Overrun: three back-to-back words, no ack
        send_word(4'hA, 0, 1'b0);
        send_word(4'h5, 0, 1'b0);
        send_word(4'hF, 0, 1'b0);
        chk("ovr_flag", overrun, exp_ovr);
        repeat (3) tick();
        chk("ovr_head_stable", data_out, 4'hA);
        pop_check("ovr_pop_A");
        pop_check("ovr_pop_5");
        chk("ovr_empty", data_valid, 1'b0);
        chk("ovr_sticky", overrun, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        exp_ovr = 1'b0;
        chk("ovr_cleared", overrun, exp_ovr);

        // Push and pop in the same cycle while full
        send_word(4'h1, 0, 1'b0);
        send_word(4'h2, 0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("pp_head_before", data_out, sb[0]);
        void'(sb.pop_front());
        data_ack = 1'b1;
        send_bit(1'b0, 1'b1);
        data_ack = 1'b0;
        model_push(4'h3);
        chk("pp_no_overrun", overrun, 1'b0);
        pop_check("pp_pop_2");
        pop_check("pp_pop_3");
        chk("pp_empty", data_valid, 1'b0);

        // Framing error: restart after two bits
        fe_cnt = 0;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        model_push(4'b0011);
        repeat (2) tick();
        chk("fe_pulse_count", fe_cnt, 1);
        pop_check("fe_word");

        // Asynchronous reset mid-word, with a word already queued
        send_word(4'hC, 0, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_data_valid", data_valid, 1'b0);
        chk("arst_data_out", data_out, 4'h0);
        sb.delete();
        #4 rst = 1'b1;
        tick();
        send_word(4'b1001, 0, 1'b0);
        pop_check("arst_new_word");
        chk("arst_final_empty", data_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/registro_serie_paralelo.md
Name: registro_serie_paralelo

Overview:
Serial-to-parallel receive stage that sits directly downstream of the 4-bit parallel-to-serial transmitter. It samples a framed MSB-first bit stream and assembles WIDTH-bit words. Completed words go into a small FIFO, and a valid/ack handshake presents them to the consumer. Overrun and framing errors are flagged for the control logic.

Parameters:
WIDTH, 4, bits per word (matches transmitter word size)
DEPTH, 2, FIFO entries holding completed words (power of 2, >=2)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  frame marker; high in the cycle carrying the first (MSB) bit of a word
serial_in  input  1  serial data bit, sampled when bit_valid=1
bit_valid  input  1  qualifies serial_in (and start) for the current cycle
data_out  output  WIDTH  FIFO head word
data_valid  output  1  FIFO not empty; data_out is meaningful
data_ack  input  1  consumer pops head word when data_valid=1
busy  output  1  word reception in progress (state SHIFT)
overrun  output  1  sticky; a completed word was dropped because FIFO was full
frame_err  output  1  one-cycle pulse; start seen mid-word
clr_err  input  1  synchronous clear of overrun

Behaviour:
- Reset (rst=0, async): state=IDLE, shift reg=0, bit counter=0, FIFO empty (rd/wr ptr=0, count=0); data_out=0, data_valid=0, busy=0, overrun=0, frame_err=0. Takes effect immediately, mid-word or not; a partial word is discarded.
- FSM states: IDLE, SHIFT.
- IDLE: cycles with bit_valid=0 are ignored. If bit_valid=1 and start=1: load serial_in as MSB, counter=1, go to SHIFT. If bit_valid=1 and start=0: ignore the bit and stay in IDLE.
- SHIFT: each bit_valid=1 cycle shifts serial_in in from the LSB side (shift reg <= {shift reg[WIDTH-2:0], serial_in}) and increments the counter. Cycles with bit_valid=0 hold state; there is no timeout.
- Word complete: when the WIDTH-th bit is shifted in, the word is pushed into the FIFO in that same edge, and the FSM returns to IDLE. The word appears on data_out/data_valid one cycle after the last bit edge if the FIFO was empty. Latency from last bit to data_valid is 1 clock.
- Back-to-back frames: start=1 with bit_valid=1 in the cycle right after completion is accepted from IDLE, so there is no dead cycle between words.
- Framing error: in SHIFT, if bit_valid=1 and start=1, the partial word is discarded. frame_err pulses high for 1 cycle. This bit is taken as the MSB of a new word (counter=1) and the FSM stays in SHIFT.
- FIFO push when full (count==DEPTH, with no pop in the same cycle): the word is dropped, overrun is set, and FIFO contents are unchanged.
- Simultaneous push and pop when full: the pop frees a slot, both succeed, count is unchanged, and overrun is not set.
- Simultaneous push and pop at count=1: head is replaced by the new word next cycle, and data_valid stays 1.
- Pop: data_ack=1 and data_valid=1 advance the rd ptr. data_ack with data_valid=0 is ignored. data_out must be stable while data_valid=1 and data_ack=0.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- overrun is cleared only by clr_err=1 or reset. If clr_err and a new overrun occur in the same cycle, set wins.
- busy=1 exactly while state==SHIFT.

Test Plan:
- Reset then single word: send 1,0,1,1 (start on first, bit_valid=1 each cycle) -> data_out=4'b1011, data_valid=1 one clock after the 4th bit. data_ack=1 -> data_valid=0 next cycle.
- Gapped bits: send 0,1,1,0 with bit_valid=0 for 2 cycles between each bit -> data_out=4'b0110, busy=1 throughout the word, and no frame_err.
- Overrun: send 3 words 4'hA, 4'h5, 4'hF with no ack -> FIFO holds A then 5, and overrun=1. Ack twice -> outputs A then 5, then data_valid=0. clr_err -> overrun=0.
- Push and pop when full: fill with 4'h1, 4'h2, then hold data_ack=1 in the cycle 4'h3 completes -> overrun=0, and the outputs sequence is 2 then 3.
- Framing error: send 1,1, then start=1 with bit 0, followed by 0,1,1 -> frame_err pulses once, and the received word is 4'b0011.
- Async reset mid-word: drive rst=0 for half a clock period after 2 bits -> all outputs 0 immediately. A new full frame 4'b1001 is then received correctly.
